// File: rtl/store_stage.sv
// Output stage of the SHAKE core: buffers a rate block from the permute stage and streams it
// out as W-bit words under ready/valid until the requested number of output bits is delivered.
module store_stage #(
  parameter int unsigned W        = 64,
  parameter int unsigned RATE_MAX = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RATE_MAX-1:0] rate_output,
  input  logic                output_buffer_we,
  output logic                output_buffer_ready,
  input  logic [1:0]          operation_mode,
  input  logic [31:0]         output_size,
  output logic [W-1:0]        data_out,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o
);

  localparam logic [7:0] Blk128 = 8'(RATE_MAX / W);
  localparam logic [7:0] Blk256 = 8'(1088 / W);

  typedef enum logic [1:0] {StIdle, StDrain, StWait} state_e;

  state_e              state_q, state_d;
  logic [RATE_MAX-1:0] buf_q, buf_d;
  logic [31:0]         words_left_q, words_left_d;
  logic [7:0]          blk_left_q, blk_left_d;

  logic [32:0] words_total;
  logic [7:0]  blk_words;
  logic [31:0] rem_bits;
  logic        handshake;

  // 33-bit sum so a size near 2^32 cannot wrap before the divide
  assign words_total = ({1'b0, output_size} + 33'(W - 1)) / 33'(W);
  assign blk_words   = (operation_mode == 2'b00) ? Blk128 : Blk256;
  assign rem_bits    = output_size % 32'(W);

  assign output_buffer_ready = (state_q != StDrain);
  assign valid_o             = (state_q == StDrain);
  assign last_o              = valid_o & (words_left_q == 32'd1);
  assign handshake           = valid_o & ready_i;

  always_comb begin
    data_out = '0;
    if (valid_o) begin
      data_out = buf_q[W-1:0];
      for (int unsigned i = 0; i < W; i++) begin
        if (last_o && (rem_bits != 32'd0) && (i >= rem_bits)) data_out[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    words_left_d = words_left_q;
    blk_left_d   = blk_left_q;
    unique case (state_q)
      StIdle: begin
        if (output_buffer_we && (output_size != 32'd0)) begin
          buf_d        = rate_output;
          words_left_d = words_total[31:0];
          blk_left_d   = blk_words;
          state_d      = StDrain;
        end
      end
      StDrain: begin
        // A write strobe here is a protocol violation and is deliberately ignored.
        if (handshake) begin
          buf_d        = buf_q >> W;
          words_left_d = words_left_q - 32'd1;
          blk_left_d   = blk_left_q - 8'd1;
          if (words_left_q == 32'd1) begin
            state_d = StIdle;
          end else if (blk_left_q == 8'd1) begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (output_buffer_we) begin
          buf_d      = rate_output;
          blk_left_d = blk_words;
          state_d    = StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      buf_q        <= '0;
      words_left_q <= '0;
      blk_left_q   <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      words_left_q <= words_left_d;
      blk_left_q   <= blk_left_d;
    end
  end

endmodule

// File: tb/tb_store_stage.sv
// Randomized bench for store_stage: a message-level model predicts the word stream from the
// written blocks and the requested size; handshakes, stalls and block waits are all checked.
module tb_store_stage;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1343:0] rate;
  logic          we;
  logic          obr;
  logic [1:0]    mode;
  logic [31:0]   size;
  logic [63:0]   dout;
  logic          vld;
  logic          rdy;
  logic          last;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_stage #(.W(64), .RATE_MAX(1344)) dut (
    .clk                (clk),
    .rst                (rst_n),
    .rate_output        (rate),
    .output_buffer_we   (we),
    .output_buffer_ready(obr),
    .operation_mode     (mode),
    .output_size        (size),
    .data_out           (dout),
    .valid_o            (vld),
    .ready_i            (rdy),
    .last_o             (last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1343:0] rand_blk();
    logic [1343:0] b;
    for (int i = 0; i < 42; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // Word j of the message: word (j mod words/block) of block (j / words/block), truncated to
  // the requested bit count on the final word.
  function automatic logic [63:0] model_word(input logic [1343:0] blk, input int j, input int bpw,
                                             input int n, input int unsigned sz);
    logic [63:0] w;
    w = blk[(j % bpw)*64 +: 64];
    if ((j == n - 1) && (sz % 64 != 0)) w &= (64'd1 << (sz % 64)) - 64'd1;
    return w;
  endfunction

  // Called at a negedge; returns at the negedge after the final handshake.
  task automatic run_msg(input logic [1:0] m, input int unsigned sz, input int unsigned rdy_pct,
                         input bit inject);
    logic [1343:0] blks[$];
    logic [63:0]   held;
    int            n, bpw, nblk, idx, cyc;
    bit            stalled, wrote, injected;
    n    = int'((64'(sz) + 63) / 64);
    bpw  = (m == 2'b00) ? 21 : 17;
    nblk = (n + bpw - 1) / bpw;
    for (int b = 0; b < nblk; b++) blks.push_back(rand_blk());
    mode = m;
    size = sz;
    check("obr_idle", 64'(obr), 64'd1);
    rate     = blks[0];
    we       = 1'b1;
    wrote    = 1'b1;
    idx      = 0;
    cyc      = 0;
    stalled  = 1'b0;
    injected = 1'b0;
    held     = '0;
    while (idx < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      we = 1'b0;
      if (wrote) check("latency_vld", 64'(vld), 64'd1);
      wrote = 1'b0;
      if (stalled) begin
        check("hold_vld", 64'(vld), 64'd1);
        check("hold_data", dout, held);
      end
      if (vld) begin
        rdy = ($urandom_range(99) < rdy_pct);
        check("obr_drain", 64'(obr), 64'd0);
        check("data", dout, model_word(blks[idx / bpw], idx, bpw, n, sz));
        check("last", 64'(last), 64'(idx == n - 1));
        if (inject && !injected && idx >= 2) begin
          rate     = rand_blk();
          we       = 1'b1;
          injected = 1'b1;
        end
        if (rdy) begin
          idx++;
          stalled = 1'b0;
        end else begin
          held    = dout;
          stalled = 1'b1;
        end
      end else begin
        check("obr_wait", 64'(obr), 64'd1);
        check("wait_at_boundary", 64'(idx % bpw), 64'd0);
        rate  = blks[idx / bpw];
        we    = 1'b1;
        wrote = 1'b1;
      end
    end
    if (idx < n) check("timeout", 64'(idx), 64'(n));
    @(negedge clk);
    we  = 1'b0;
    rdy = 1'b0;
    check("end_vld", 64'(vld), 64'd0);
    check("end_obr", 64'(obr), 64'd1);
    check("end_last", 64'(last), 64'd0);
  endtask

  initial begin
    logic [1343:0] blk;
    rst_n = 1'b0;
    rate  = '0;
    we    = 1'b0;
    mode  = 2'b00;
    size  = 32'd0;
    rdy   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_vld", 64'(vld), 64'd0);
    check("rst_obr", 64'(obr), 64'd1);
    check("rst_data", dout, 64'd0);
    check("rst_last", 64'(last), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_msg(2'b00, 256, 100, 1'b0);
    run_msg(2'b01, 1200, 100, 1'b0);
    run_msg(2'b00, 100, 100, 1'b0);
    run_msg(2'b00, 1344, 50, 1'b0);
    run_msg(2'b01, 3000, 60, 1'b1);
    run_msg(2'b10, 2000, 70, 1'b1);
    for (int t = 0; t < 6; t++) begin
      run_msg(2'($urandom_range(2)), $urandom_range(1, 4000), $urandom_range(30, 100), 1'b1);
    end

    // Zero-length request: the block is dropped.
    size = 32'd0;
    rate = rand_blk();
    we   = 1'b1;
    @(negedge clk);
    we = 1'b0;
    check("zero_vld", 64'(vld), 64'd0);
    check("zero_obr", 64'(obr), 64'd1);
    @(negedge clk);
    check("zero_vld2", 64'(vld), 64'd0);

    // Reset while word 5 of 21 is presented.
    blk  = rand_blk();
    mode = 2'b00;
    size = 32'd1344;
    rate = blk;
    we   = 1'b1;
    rdy  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we = 1'b0;
    end
    @(negedge clk);
    check("pre_rst_word4", dout, blk[4*64 +: 64]);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_vld", 64'(vld), 64'd0);
    check("mid_rst_obr", 64'(obr), 64'd1);
    check("mid_rst_data", dout, 64'd0);
    rst_n = 1'b1;
    rdy   = 1'b0;
    @(negedge clk);
    check("post_rst_vld", 64'(vld), 64'd0);
    run_msg(2'b00, 64, 100, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_stage.md
# store_stage

Final pipeline stage of the SHAKE core, mirroring `load_stage` on the output side. It accepts a full rate block from the permute stage through the output-buffer handshake. It streams that block out as `w`-bit words under a ready/valid handshake until `output_size` bits have been delivered, requesting further squeeze blocks as needed.

## Interface

- `W`, default 64 (`keccak_pkg::w`): output word width.
- `RATE_MAX`, default 1344 (`RATE_SHAKE128`): width of the rate block bus.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous and active-low.
- `rate_output`  in  RATE_MAX  rate block from the permute stage; word i = `rate_output[i*W +: W]`.
- `output_buffer_we`  in  1  one-cycle write strobe; `rate_output` is valid this cycle.
- `output_buffer_ready`  out  1  buffer empty; permute stage may write.
- `operation_mode`  in  2  00 = SHAKE128 (21 words/block); 01 = SHAKE256 (17 words/block); 1x treated as SHAKE256. Stable for the whole message.
- `output_size`  in  32  requested output length in bits. Stable for the whole message.
- `data_out`  out  W  output word.
- `valid_o`  out  1  `data_out` is valid.
- `ready_i`  in  1  consumer accepts the word.
- `last_o`  out  1  high with the final word of the message.

## Operation

- State `IDLE`:
  - `output_buffer_ready` = 1.
  - On `output_buffer_we`: load `rate_output` into the buffer and load `words_left = ceil(output_size / W)` (33-bit intermediate, no overflow). Set `blk_left` = words/block for the mode. Go to `DRAIN`.
  - If `output_size == 0`: drop the block and stay in `IDLE`.
- State `DRAIN`:
  - `output_buffer_ready` = 0. `valid_o` = 1 and `data_out` = buffer[W-1:0].
  - On handshake (`valid_o & ready_i`): shift the buffer right by W, then decrement `words_left` and `blk_left`.
  - After a handshake: if `words_left` reaches 0, go to `IDLE`; the rest of the block is discarded. Otherwise, if `blk_left` reaches 0, go to `WAIT`.
- State `WAIT`:
  - `output_buffer_ready` = 1; `valid_o` = 0.
  - On `output_buffer_we`: load the buffer, reload `blk_left` and go to `DRAIN`. `words_left` is not reloaded.
- `last_o` = `valid_o & (words_left == 1)`.
- Partial final word: if `output_size mod W = r != 0`, then on the last word bits `[W-1:r]` of `data_out` are forced to 0.
- `output_buffer_we` while in `DRAIN` is a protocol violation. It must be ignored: buffer, counters and outputs are unchanged.
- `output_buffer_ready` is a combinational decode of the state: 1 in `IDLE`/`WAIT`, 0 in `DRAIN`.

## Timing

- Reset (`rst` = 0 at a clock edge) gives: state `IDLE`, buffer = 0, counters = 0, `valid_o` = 0, `data_out` = 0, `last_o` = 0, `output_buffer_ready` = 1.
- Reset mid-message discards all pending words; the next cycle is as after reset.
- Latency: `output_buffer_we` at cycle n gives `valid_o` = 1 with word 0 at cycle n+1.
- Throughput: 1 word/cycle while `ready_i` is held high.
- `data_out` and `last_o` hold stable while `valid_o & !ready_i`. `valid_o` never drops without a handshake.
- Last word of a block accepted at cycle k with `words_left > 0`:
  - `WAIT` at k+1 with `output_buffer_ready` = 1.
  - The earliest write at k+1 gives the next word at k+2, a minimum one-cycle bubble per block.
- Final handshake at cycle k: `IDLE` at k+1 with `valid_o` = 0 and `output_buffer_ready` = 1.
  - A new message's first block may be written at k+1.

## Test plan

- SHAKE128, `output_size` = 256, `ready_i` = 1:
  - Required: 4 words equal to `rate_output[255:0]` in 64-bit slices, on cycles n+1..n+4; `last_o` on the 4th word only.
  - Afterwards `output_buffer_ready` = 1 and the remaining 17 words are discarded.
- SHAKE256, `output_size` = 1200:
  - Required: 17 words from block 1, then `WAIT` with `output_buffer_ready` = 1.
  - Second write: 2 words follow; word 19 has bits [63:48] = 0 and `last_o` = 1.
- SHAKE128, `output_size` = 100:
  - Required: 2 words; word 2 has bits [63:36] zeroed; `last_o` on word 2.
- Backpressure: toggle `ready_i` pseudo-randomly during a 21-word block.
  - Required: `data_out`/`valid_o` stable while stalled; no word lost or duplicated; exactly 21 handshakes.
- `output_buffer_we` pulsed mid-`DRAIN` with a different block:
  - Required: output stream is unchanged.
- `rst` = 0 at word 5 of 21:
  - Required: `valid_o` = 0 next cycle and `output_buffer_ready` = 1.
  - A new message with `output_size` = 64 then yields exactly 1 word with `last_o` = 1.
